// File: rtl/game_pkg.sv
// Shared definitions for the bullet/heart hit resolver: colour codes,
// 16-bit box field packing, FSM states and the unpacked box view.
package game_pkg;

  localparam logic [2:0] COLOR_WHITE = 3'b000;
  localparam logic [2:0] COLOR_GREEN = 3'b001;
  localparam logic [2:0] COLOR_BLUE  = 3'b010;

  // Position word carries x/y, size word carries w/h, same bit slots.
  localparam int unsigned X_HI = 15;
  localparam int unsigned X_LO = 8;
  localparam int unsigned Y_HI = 7;
  localparam int unsigned Y_LO = 0;
  localparam int unsigned W_HI = X_HI;
  localparam int unsigned W_LO = X_LO;
  localparam int unsigned H_HI = Y_HI;
  localparam int unsigned H_LO = Y_LO;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK1,
    ST_CHECK2,
    ST_RESOLVE
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] w;
    logic [7:0] h;
  } box_t;

  function automatic box_t make_box(input logic [15:0] pos, input logic [15:0] size);
    box_t bx;
    bx.x = pos[X_HI:X_LO];
    bx.y = pos[Y_HI:Y_LO];
    bx.w = size[W_HI:W_LO];
    bx.h = size[H_HI:H_LO];
    return bx;
  endfunction

  // Blue only hurts a heart that moved since the previous frame.
  function automatic logic is_damaging(input logic [2:0] color, input logic moved);
    return (color == COLOR_WHITE) || ((color == COLOR_BLUE) && moved);
  endfunction

endpackage

// File: rtl/bullet_collision_if.sv
// Bundle between the Bullet generator / player logic and the hit resolver.
interface bullet_collision_if;
  logic        frameTick;
  logic [15:0] playerPos;
  logic [15:0] playerSize;
  logic [15:0] position1;
  logic [15:0] size1;
  logic [2:0]  color1;
  logic        isRender1;
  logic [15:0] position2;
  logic [15:0] size2;
  logic [2:0]  color2;
  logic        isRender2;
  logic        isCollide;
  logic [1:0]  hitMask;
  logic [7:0]  hp;
  logic        isInvuln;
  logic        isDead;

  modport master (
    output frameTick, playerPos, playerSize,
    output position1, size1, color1, isRender1,
    output position2, size2, color2, isRender2,
    input  isCollide, hitMask, hp, isInvuln, isDead
  );

  modport slave (
    input  frameTick, playerPos, playerSize,
    input  position1, size1, color1, isRender1,
    input  position2, size2, color2, isRender2,
    output isCollide, hitMask, hp, isInvuln, isDead
  );
endinterface

// File: rtl/aabb_overlap.sv
// Axis-aligned box overlap test; far edges computed in 9 bits so x+w never wraps.
module aabb_overlap
  import game_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic hit
);

  logic [8:0] a_xe, a_ye, b_xe, b_ye;
  logic       degenerate;

  always_comb begin
    a_xe = {1'b0, a.x} + {1'b0, a.w};
    a_ye = {1'b0, a.y} + {1'b0, a.h};
    b_xe = {1'b0, b.x} + {1'b0, b.w};
    b_ye = {1'b0, b.y} + {1'b0, b.h};
    degenerate = (a.w == '0) || (a.h == '0) || (b.w == '0) || (b.h == '0);
    hit = !degenerate
        && ({1'b0, a.x} < b_xe) && ({1'b0, b.x} < a_xe)
        && ({1'b0, a.y} < b_ye) && ({1'b0, b.y} < a_ye);
  end

endmodule

// File: rtl/bullet_collision.sv
// Per-frame hit resolver: snapshots two bullets and the heart box, tests each
// bullet in turn through one shared overlap unit, then updates HP/invulnerability.
module bullet_collision
  import game_pkg::*;
#(
  parameter int unsigned MAX_HP        = 20,
  parameter int unsigned DAMAGE        = 1,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input  logic                clk,
  input  logic                rst_n,
  bullet_collision_if.slave   bus
);

  state_t state_q, state_d;

  box_t       player_q, b1_q, b2_q, bullet_op;
  logic [2:0] col1_q, col2_q;
  logic       ren1_q, ren2_q;
  logic       moved_q;
  logic [15:0] prev_pos_q;
  logic       prev_valid_q;
  logic       hit1_q, hit2_q;
  logic       ovl_hit;

  logic [7:0] hp_q, cnt_q;
  logic [1:0] mask_q;
  logic       collide_q, dead_q;

  logic              dmg1, dmg2, grn1, grn2, invuln, applied;
  logic [1:0]        n_dmg, n_grn;
  logic signed [9:0] dmg_amt, hp_sum;
  logic [7:0]        hp_new, cnt_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (bus.frameTick && !dead_q) state_d = ST_CHECK1;
      ST_CHECK1:  state_d = ST_CHECK2;
      ST_CHECK2:  state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Single overlap unit, bullet operand selected by which check is running.
  always_comb begin
    bullet_op = (state_q == ST_CHECK1) ? b1_q : b2_q;
  end

  aabb_overlap u_overlap (
    .a   (player_q),
    .b   (bullet_op),
    .hit (ovl_hit)
  );

  always_comb begin
    dmg1   = hit1_q && is_damaging(col1_q, moved_q);
    dmg2   = hit2_q && is_damaging(col2_q, moved_q);
    grn1   = hit1_q && (col1_q == COLOR_GREEN);
    grn2   = hit2_q && (col2_q == COLOR_GREEN);
    n_dmg  = {1'b0, dmg1} + {1'b0, dmg2};
    n_grn  = {1'b0, grn1} + {1'b0, grn2};
    invuln = (cnt_q != '0);

    dmg_amt = invuln ? '0 : $signed(10'(n_dmg) * 10'(DAMAGE));
    hp_sum  = $signed({2'b00, hp_q}) - dmg_amt + $signed({8'b0, n_grn});

    if (hp_sum < 0)
      hp_new = '0;
    else if (hp_sum > $signed(10'(MAX_HP)))
      hp_new = 8'(MAX_HP);
    else
      hp_new = hp_sum[7:0];

    applied = (dmg_amt != '0);
    if (applied)
      cnt_new = 8'(INVULN_FRAMES);
    else if (invuln)
      cnt_new = cnt_q - 8'd1;
    else
      cnt_new = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      player_q     <= '0;
      b1_q         <= '0;
      b2_q         <= '0;
      col1_q       <= '0;
      col2_q       <= '0;
      ren1_q       <= 1'b0;
      ren2_q       <= 1'b0;
      moved_q      <= 1'b0;
      prev_pos_q   <= '0;
      prev_valid_q <= 1'b0;
      hit1_q       <= 1'b0;
      hit2_q       <= 1'b0;
      hp_q         <= 8'(MAX_HP);
      cnt_q        <= '0;
      mask_q       <= '0;
      collide_q    <= 1'b0;
      dead_q       <= 1'b0;
    end else begin
      collide_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.frameTick && !dead_q) begin
            player_q     <= make_box(bus.playerPos, bus.playerSize);
            b1_q         <= make_box(bus.position1, bus.size1);
            b2_q         <= make_box(bus.position2, bus.size2);
            col1_q       <= bus.color1;
            col2_q       <= bus.color2;
            ren1_q       <= bus.isRender1;
            ren2_q       <= bus.isRender2;
            // First frame after reset has no reference position.
            moved_q      <= prev_valid_q && (bus.playerPos != prev_pos_q);
            prev_pos_q   <= bus.playerPos;
            prev_valid_q <= 1'b1;
          end
        end
        ST_CHECK1: hit1_q <= ren1_q && ovl_hit;
        ST_CHECK2: hit2_q <= ren2_q && ovl_hit;
        ST_RESOLVE: begin
          hp_q      <= hp_new;
          cnt_q     <= cnt_new;
          mask_q    <= {hit2_q, hit1_q};
          collide_q <= dmg1 || dmg2;
          dead_q    <= (hp_new == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.isCollide = collide_q;
  assign bus.hitMask   = mask_q;
  assign bus.hp        = hp_q;
  assign bus.isInvuln  = (cnt_q != '0);
  assign bus.isDead    = dead_q;

endmodule
